// File: rtl/rtc_display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan logic.
package rtc_display_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} scan_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] DIG_OFF = 8'hFF;

  // One-hot active-low digit select; unused high digits stay at 1.
  function automatic logic [7:0] digit_sel(input logic [2:0] idx);
    logic [7:0] sel;
    sel      = DIG_OFF;
    sel[idx] = 1'b0;
    return sel;
  endfunction

endpackage

// File: rtl/rtc_slot_timer.sv
// Per-slot cycle counter with the blank-end, on-end and slot-end compare strobes.
module rtc_slot_timer #(
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned STEP_CYCLES  = 1024,
  parameter int unsigned SLOT_CYCLES  = BLANK_CYCLES + 16 * STEP_CYCLES,
  parameter int unsigned CW           = $clog2(SLOT_CYCLES)
) (
  input  logic       sclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       run,
  input  logic [3:0] bright,
  output logic       blank_end,
  output logic       on_end,
  output logic       pre_end,
  output logic       slot_end
);

  logic [CW-1:0] cyc_q;
  logic [CW-1:0] on_last;

  assign on_last = CW'(BLANK_CYCLES - 1) + CW'(bright) * CW'(STEP_CYCLES);

  // Held at zero while idle so the first slot after enable starts at cyc 0.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
    end else if (!enable || !run || slot_end) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  assign blank_end = (cyc_q == CW'(BLANK_CYCLES - 1));
  assign on_end    = (cyc_q == on_last);
  assign pre_end   = (cyc_q == CW'(SLOT_CYCLES - 2));
  assign slot_end  = (cyc_q == CW'(SLOT_CYCLES - 1));

endmodule

// File: rtl/rtc_scan_ctrl.sv
// Scan scheduler for the 7-segment array: slot FSM, per-slot input latches, registered pins.
module rtc_scan_ctrl
  import rtc_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned STEP_CYCLES  = 1024
) (
  input  logic                    i_sclk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [3:0]              i_brightness,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  input  logic [8*NUM_DIGITS-1:0] i_seg_data,
  output logic [7:0]              o_segments,
  output logic [7:0]              o_digits,
  output logic [2:0]              o_active_digit,
  output logic                    o_frame_tick
);

  localparam int unsigned SLOT_CYCLES = BLANK_CYCLES + 16 * STEP_CYCLES;
  localparam int unsigned CW          = $clog2(SLOT_CYCLES);
  localparam logic [2:0]  LAST_DIG    = 3'(NUM_DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  logic [3:0]  bright_q;
  logic        mask_q;
  logic [7:0]  pat_q;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  dig_q, dig_d;
  logic        tick_q, tick_d;
  logic        latch;
  logic        blank_end, on_end, pre_end, slot_end;

  rtc_slot_timer #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .STEP_CYCLES  (STEP_CYCLES),
    .SLOT_CYCLES  (SLOT_CYCLES),
    .CW           (CW)
  ) u_timer (
    .sclk      (i_sclk),
    .reset_n   (i_reset_n),
    .enable    (i_enable),
    .run       (state_q != IDLE),
    .bright    (bright_q),
    .blank_end (blank_end),
    .on_end    (on_end),
    .pre_end   (pre_end),
    .slot_end  (slot_end)
  );

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    latch   = 1'b0;
    if (!i_enable) begin
      state_d = IDLE;
      digit_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          digit_d = '0;
          latch   = 1'b1;
        end
        BLANK: if (blank_end) state_d = (bright_q != 4'd0 && !mask_q) ? ON : OFF;
        ON:    if (on_end) state_d = OFF;
        OFF: begin
          if (slot_end) begin
            state_d = BLANK;
            digit_d = (digit_q == LAST_DIG) ? 3'd0 : digit_q + 3'd1;
            latch   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs are computed from the next state so the pins track the FSM with no lag.
    seg_d  = (state_d == ON) ? pat_q : SEG_OFF;
    dig_d  = (state_d == ON) ? digit_sel(digit_q) : DIG_OFF;
    tick_d = i_enable && (state_q != IDLE) && pre_end && (digit_q == LAST_DIG);
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      digit_q  <= '0;
      bright_q <= '0;
      mask_q   <= 1'b0;
      pat_q    <= SEG_OFF;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      tick_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
      if (latch) begin
        bright_q <= i_brightness;
        mask_q   <= i_blank_mask[digit_d];
        pat_q    <= i_seg_data[{digit_d, 3'b000} +: 8];
      end
    end
  end

  assign o_segments     = seg_q;
  assign o_digits       = dig_q;
  assign o_active_digit = digit_q;
  assign o_frame_tick   = tick_q;

endmodule

// File: tb/tb_rtc_scan_ctrl.sv
// Directed bench for rtc_scan_ctrl with BLANK_CYCLES=2, STEP_CYCLES=1 (slot 18, frame 108).
module tb_rtc_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  brightness;
  logic [5:0]  mask;
  logic [47:0] seg_data;
  logic [7:0]  segments;
  logic [7:0]  digits;
  logic [2:0]  active_digit;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the slot position and the values latched at slot start.
  int         m_run = 0, m_cyc = 0, m_dig = 0, m_bright = 0, m_mask = 0;
  logic [7:0] m_pat = 8'hFF;
  int         gcnt = 0;

  rtc_scan_ctrl #(
    .NUM_DIGITS   (6),
    .BLANK_CYCLES (2),
    .STEP_CYCLES  (1)
  ) dut (
    .i_sclk         (clk),
    .i_reset_n      (rst_n),
    .i_enable       (enable),
    .i_brightness   (brightness),
    .i_blank_mask   (mask),
    .i_seg_data     (seg_data),
    .o_segments     (segments),
    .o_digits       (digits),
    .o_active_digit (active_digit),
    .o_frame_tick   (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_latch();
    m_bright = int'(brightness);
    m_mask   = int'(mask[m_dig]);
    m_pat    = seg_data[8*m_dig +: 8];
  endtask

  task automatic check_all();
    bit on;
    on = (m_run != 0) && (m_mask == 0) && (m_cyc >= 2) && (m_cyc < 2 + m_bright);
    chk("digits", {24'd0, digits}, on ? {24'd0, ~(8'd1 << m_dig)} : 32'hFF);
    chk("segments", {24'd0, segments}, on ? {24'd0, m_pat} : 32'hFF);
    chk("active", {29'd0, active_digit}, m_dig);
    chk("tick", {31'd0, frame_tick}, {31'd0, (m_run != 0 && m_cyc == 17 && m_dig == 5)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || !enable) begin
      m_run = 0; m_cyc = 0; m_dig = 0;
    end else if (m_run == 0) begin
      m_run = 1; m_cyc = 0; m_dig = 0;
      model_latch();
    end else if (m_cyc == 17) begin
      m_cyc = 0;
      m_dig = (m_dig == 5) ? 0 : m_dig + 1;
      model_latch();
    end else begin
      m_cyc++;
    end
    gcnt++;
    @(negedge clk);
    check_all();
  endtask

  logic [7:0] seq [7];
  int         on_cnt [13];
  int         tick_at [$];
  int         act2 = 0;
  logic [7:0] seg_s0 = 8'h00, seg_s6 = 8'h00;

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    brightness = 4'd4;
    mask       = 6'b000000;
    seg_data   = {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hC0};
    for (int i = 0; i < 13; i++) on_cnt[i] = 0;

    // Reset held with enable high: everything dark.
    repeat (3) tick();
    chk("rst_seg", {24'd0, segments}, 32'hFF);
    chk("rst_dig", {24'd0, digits}, 32'hFF);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_act", {29'd0, active_digit}, 32'd0);
    rst_n = 1'b1;
    gcnt  = 0;

    for (int s = 0; s < 13; s++) begin
      for (int c = 0; c < 18; c++) begin
        tick();
        if (s == 0 && c < 2) chk("pre_select", {24'd0, digits}, 32'hFF);
        if (s == 0 && c == 2) chk("first_select", {24'd0, digits}, 32'hFE);
        if (c == 2 && s < 7) seq[s] = digits;
        if (digits != 8'hFF) on_cnt[s]++;
        if (frame_tick) tick_at.push_back(gcnt);
        if (s == 8 && active_digit == 3'd2) act2++;
        if (s == 0 && c == 4) seg_s0 = segments;
        if (s == 6 && c == 2) seg_s6 = segments;
        // Mid-slot input changes must only take effect from the next latch.
        if (s == 0 && c == 3) begin
          brightness    = 4'd15;
          seg_data[7:0] = 8'h40;
        end
        if (s == 6 && c == 5) mask = 6'b000100;
        if (s == 9 && c == 0) mask = 6'b000000;
      end
    end

    chk("seq0", {24'd0, seq[0]}, 32'hFE);
    chk("seq1", {24'd0, seq[1]}, 32'hFD);
    chk("seq2", {24'd0, seq[2]}, 32'hFB);
    chk("seq3", {24'd0, seq[3]}, 32'hF7);
    chk("seq4", {24'd0, seq[4]}, 32'hEF);
    chk("seq5", {24'd0, seq[5]}, 32'hDF);
    chk("seq_wrap", {24'd0, seq[6]}, 32'hFE);
    chk("on_slot0", on_cnt[0], 32'd4);
    chk("on_slot1", on_cnt[1], 32'd15);
    chk("on_slot6", on_cnt[6], 32'd15);
    chk("on_masked", on_cnt[8], 32'd0);
    chk("masked_len", act2, 32'd18);
    chk("old_pattern", {24'd0, seg_s0}, 32'hC0);
    chk("new_pattern", {24'd0, seg_s6}, 32'h40);
    chk("tick_count", tick_at.size(), 32'd2);
    if (tick_at.size() == 2) begin
      chk("tick_first", tick_at[0], 32'd108);
      chk("tick_period", tick_at[1] - tick_at[0], 32'd108);
    end

    // Advance to cyc 5 of the digit-3 slot (slot 15), then drop enable mid-ON.
    repeat (42) tick();
    chk("dig3_on", {24'd0, digits}, 32'hF7);
    enable = 1'b0;
    tick();
    chk("dis_dig", {24'd0, digits}, 32'hFF);
    chk("dis_seg", {24'd0, segments}, 32'hFF);
    chk("dis_act", {29'd0, active_digit}, 32'd0);
    repeat (3) tick();
    enable = 1'b1;
    tick();
    chk("re_blank0", {24'd0, digits}, 32'hFF);
    tick();
    chk("re_blank1", {24'd0, digits}, 32'hFF);
    tick();
    chk("re_select", {24'd0, digits}, 32'hFE);
    chk("re_seg", {24'd0, segments}, 32'h40);
    repeat (3) tick();

    // Asynchronous reset mid-ON: outputs dark before the next clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_dig", {24'd0, digits}, 32'hFF);
    chk("arst_seg", {24'd0, segments}, 32'hFF);
    chk("arst_act", {29'd0, active_digit}, 32'd0);
    m_run = 0; m_cyc = 0; m_dig = 0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_sel", {24'd0, digits}, 32'hFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
